// File: rtl/mdio_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdio_master_ctrl
// Brief    : Clause-22 MDIO management master; one frame per host command,
//            MDC divided from clk. MDIO_PREAMBLE_SUPPRESS_EN adds cfg_no_pre.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_master_ctrl #(
   parameter int MDC_DIV      = 10,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_read,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   input  logic        cfg_no_pre,
`endif
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_out,
   output logic        mdio_oe,
   input  logic        mdio_in
);

   localparam logic [3:0] c_st_idle = 4'd0;
   localparam logic [3:0] c_st_pre  = 4'd1;
   localparam logic [3:0] c_st_st   = 4'd2;
   localparam logic [3:0] c_st_op   = 4'd3;
   localparam logic [3:0] c_st_phy  = 4'd4;
   localparam logic [3:0] c_st_reg  = 4'd5;
   localparam logic [3:0] c_st_ta   = 4'd6;
   localparam logic [3:0] c_st_data = 4'd7;
   localparam logic [3:0] c_st_done = 4'd8;

   localparam int                 c_div_w    = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(MDC_DIV - 1);
   localparam logic [4:0]         c_pre_last = 5'(PREAMBLE_LEN - 1);

   logic [3:0]         r_state;
   logic [3:0]         w_state_nxt;
   logic [c_div_w-1:0] r_div_cnt;
   logic               r_mdc;
   logic [4:0]         r_bit_cnt;
   logic [4:0]         w_bit_lim;
   logic [31:0]        r_tx_sr;
   logic [15:0]        r_rx_sr;
   logic               r_read;
   logic               r_ta_hi;
   logic [15:0]        r_rsp_rdata;
   logic               r_rsp_err;
   logic               w_accept;
   logic               w_skip_pre;
   logic               w_active;
   logic               w_div_tc;
   logic               w_bit_end;
   logic               w_sample;
   logic               w_last_bit;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign w_skip_pre = cfg_no_pre;
`else
   assign w_skip_pre = 1'b0;
`endif

   assign w_accept   = cmd_valid & cmd_ready;
   assign w_active   = (r_state != c_st_idle) && (r_state != c_st_done);
   assign w_div_tc   = (r_div_cnt == c_div_last);
   // New bit is driven on the mdc 1->0 toggle, mdio_in sampled on the 0->1 toggle
   assign w_bit_end  = w_active & w_div_tc & r_mdc;
   assign w_sample   = w_active & w_div_tc & ~r_mdc;
   assign w_last_bit = w_bit_end && (r_bit_cnt == w_bit_lim);

   always_comb begin
      w_bit_lim = 5'd1;
      case (r_state)
         c_st_pre:  w_bit_lim = c_pre_last;
         c_st_phy:  w_bit_lim = 5'd4;
         c_st_reg:  w_bit_lim = 5'd4;
         c_st_data: w_bit_lim = 5'd15;
         default:   w_bit_lim = 5'd1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= c_st_idle;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (w_accept)   w_state_nxt = w_skip_pre ? c_st_st : c_st_pre;
         c_st_pre:  if (w_last_bit) w_state_nxt = c_st_st;
         c_st_st:   if (w_last_bit) w_state_nxt = c_st_op;
         c_st_op:   if (w_last_bit) w_state_nxt = c_st_phy;
         c_st_phy:  if (w_last_bit) w_state_nxt = c_st_reg;
         c_st_reg:  if (w_last_bit) w_state_nxt = c_st_ta;
         c_st_ta:   if (w_last_bit) w_state_nxt = c_st_data;
         c_st_data: if (w_last_bit) w_state_nxt = c_st_done;
         c_st_done: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      cmd_ready = (r_state == c_st_idle) & ~reset;
      busy      = (r_state != c_st_idle);
      rsp_valid = (r_state == c_st_done);
      mdio_out  = 1'b1;
      mdio_oe   = 1'b0;
      case (r_state)
         c_st_pre: mdio_oe = 1'b1;
         c_st_st, c_st_op, c_st_phy, c_st_reg: begin
            mdio_out = r_tx_sr[31];
            mdio_oe  = 1'b1;
         end
         c_st_ta, c_st_data: begin
            mdio_out = r_tx_sr[31];
            mdio_oe  = ~r_read;
         end
         default: ;
      endcase
   end

   assign mdc       = r_mdc;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt   <= '0;
         r_mdc       <= 1'b0;
         r_bit_cnt   <= 5'd0;
         r_tx_sr     <= 32'h0;
         r_rx_sr     <= 16'h0;
         r_read      <= 1'b0;
         r_ta_hi     <= 1'b0;
         r_rsp_rdata <= 16'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_active) begin
            if (w_div_tc) begin
               r_div_cnt <= '0;
               r_mdc     <= ~r_mdc;
            end else begin
               r_div_cnt <= r_div_cnt + 1'b1;
            end
         end else begin
            r_div_cnt <= '0;
            r_mdc     <= 1'b0;
         end

         if (r_state != w_state_nxt) r_bit_cnt <= 5'd0;
         else if (w_bit_end)         r_bit_cnt <= r_bit_cnt + 5'd1;

         // Everything after the preamble is shifted out of one frame register
         if (w_accept) begin
            r_read  <= cmd_read;
            r_ta_hi <= 1'b0;
            r_tx_sr <= {2'b01, (cmd_read ? 2'b10 : 2'b01), cmd_phy_addr, cmd_reg_addr,
                        (cmd_read ? 2'b11 : 2'b10), (cmd_read ? 16'hFFFF : cmd_wdata)};
         end else if (w_bit_end && (r_state != c_st_pre)) begin
            r_tx_sr <= {r_tx_sr[30:0], 1'b1};
         end

         if (w_sample && (r_state == c_st_ta) && (r_bit_cnt == 5'd1)) r_ta_hi <= mdio_in;
         if (w_sample && (r_state == c_st_data)) r_rx_sr <= {r_rx_sr[14:0], mdio_in};

         if ((r_state == c_st_data) && (w_state_nxt == c_st_done)) begin
            if (r_read) begin
               r_rsp_rdata <= r_rx_sr;
               r_rsp_err   <= r_ta_hi;
            end else begin
               r_rsp_err   <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdio_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_master_ctrl
// Brief    : Self-checking bench for mdio_master_ctrl against a bit-list frame
//            model with a PHY slave; MDIO_PREAMBLE_SUPPRESS_EN aware.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_master_ctrl;

   localparam int D   = 2;
   localparam int PRE = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_read = 1'b0;
   logic [4:0]  cmd_phy_addr = 5'd0;
   logic [4:0]  cmd_reg_addr = 5'd0;
   logic [15:0] cmd_wdata = 16'h0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   logic        cfg_no_pre = 1'b0;
`endif
   logic        mdio_in = 1'b1;
   logic        cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_out, mdio_oe;
   logic [15:0] rsp_rdata;

   mdio_master_ctrl #(.MDC_DIV(D), .PREAMBLE_LEN(PRE)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_read     (cmd_read),
      .cmd_phy_addr (cmd_phy_addr),
      .cmd_reg_addr (cmd_reg_addr),
      .cmd_wdata    (cmd_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      .cfg_no_pre   (cfg_no_pre),
`endif
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .busy         (busy),
      .mdc          (mdc),
      .mdio_out     (mdio_out),
      .mdio_oe      (mdio_oe),
      .mdio_in      (mdio_in)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: one entry per MDIO bit (master value, master drives, slave value)
   bit          q_out[$];
   bit          q_oe[$];
   bit          q_slv[$];
   bit          m_active = 1'b0;
   int          m_c = 0;
   int          m_last = 0;
   bit          m_rd = 1'b0;
   logic [15:0] m_exp_rdata = 16'h0;
   bit          m_exp_err = 1'b0;
   logic [15:0] m_rd_hold = 16'h0;
   bit          m_rd_known = 1'b1;
   int          m_acc_cnt = 0;
   int          slv_mode = 0;        // 0 no PHY, 1 PHY answers, 2 PHY leaves TA2 high
   logic [15:0] slv_data = 16'h0;

   function automatic void push(input bit o, input bit e, input bit s);
      q_out.push_back(o);
      q_oe.push_back(e);
      q_slv.push_back(s);
   endfunction

   function automatic void build_frame(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                                       input logic [15:0] wd, input bit np);
      q_out.delete(); q_oe.delete(); q_slv.delete();
      if (!np) for (int i = 0; i < PRE; i++) push(1'b1, 1'b1, 1'b1);
      push(1'b0, 1'b1, 1'b1); push(1'b1, 1'b1, 1'b1);
      push(rd, 1'b1, 1'b1);   push(!rd, 1'b1, 1'b1);
      for (int i = 4; i >= 0; i--) push(pa[i], 1'b1, 1'b1);
      for (int i = 4; i >= 0; i--) push(ra[i], 1'b1, 1'b1);
      if (rd) begin
         push(1'b1, 1'b0, 1'b1);
         push(1'b1, 1'b0, (slv_mode == 1) ? 1'b0 : 1'b1);
         for (int i = 15; i >= 0; i--) push(1'b1, 1'b0, (slv_mode == 0) ? 1'b1 : slv_data[i]);
         m_exp_rdata = (slv_mode == 0) ? 16'hFFFF : slv_data;
         m_exp_err   = (slv_mode != 1);
      end else begin
         push(1'b1, 1'b1, 1'b1); push(1'b0, 1'b1, 1'b1);
         for (int i = 15; i >= 0; i--) push(wd[i], 1'b1, 1'b1);
         m_exp_err = 1'b0;
      end
      m_rd   = rd;
      m_last = q_out.size() * 2 * D + 1;
   endfunction

   function automatic logic pad_val();
      int b;
      if (!m_active || (m_c >= m_last)) return 1'b1;
      b = (m_c - 1) / (2 * D);
      return q_oe[b] ? q_out[b] : q_slv[b];
   endfunction

   task automatic tick();
      bit np;
      @(posedge clk);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      np = cfg_no_pre;
`else
      np = 1'b0;
`endif
      if (reset) begin
         m_active = 1'b0; m_c = 0; m_rd_hold = 16'h0; m_rd_known = 1'b1;
      end else if (m_active) begin
         if (m_c == m_last) m_active = 1'b0;
         else begin
            m_c++;
            if (m_c == m_last) begin
               if (m_rd) begin m_rd_hold = m_exp_rdata; m_rd_known = 1'b1; end
               else m_rd_known = 1'b0;
            end
         end
      end else if (cmd_valid) begin
         build_frame(cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata, np);
         m_active = 1'b1; m_c = 1; m_acc_cnt++;
      end
      #1;
      mdio_in = pad_val();
   endtask

   always @(negedge clk) begin : cmp
      bit in_bits, e_mdc, e_oe, e_out;
      int b, ph;
      if (chk_en) begin
         in_bits = m_active && (m_c < m_last);
         e_mdc = 1'b0; e_oe = 1'b0; e_out = 1'b1;
         if (in_bits) begin
            b = (m_c - 1) / (2 * D);
            ph = (m_c - 1) % (2 * D);
            e_mdc = (ph >= D);
            e_oe  = q_oe[b];
            e_out = q_out[b];
         end
         chk("cmd_ready", cmd_ready, !m_active && !reset);
         chk("busy", busy, m_active);
         chk("rsp_valid", rsp_valid, m_active && (m_c == m_last));
         chk("mdc", mdc, e_mdc);
         chk("mdio_oe", mdio_oe, e_oe);
         if (e_oe || !in_bits) chk("mdio_out", mdio_out, e_out);
         if (m_active && (m_c == m_last)) chk("rsp_err", rsp_err, m_exp_err);
         if (m_rd_known) chk("rsp_rdata", rsp_rdata, m_rd_hold);
      end
   end

   task automatic scramble();
      cmd_read     = 1'($urandom);
      cmd_phy_addr = 5'($urandom);
      cmd_reg_addr = 5'($urandom);
      cmd_wdata    = 16'($urandom);
   endtask

   task automatic send(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, output int waited);
      int a0;
      cmd_read = rd; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd;
      cmd_valid = 1'b1;
      a0 = m_acc_cnt;
      waited = 0;
      while ((m_acc_cnt == a0) && (waited < 1000)) begin
         tick();
         waited++;
      end
      cmd_valid = 1'b0;
      scramble();
   endtask

   // Watches one frame from its first cycle up to the rsp_valid cycle
   task automatic observe(output logic [63:0] cap, output int ncap, output int rv_k,
                          output int oe0, output int rdy0, output logic [15:0] rdat,
                          output logic er);
      logic pm;
      cap = '0; ncap = 0; rv_k = -1; oe0 = 0; rdy0 = 0; rdat = 16'h0; er = 1'b0; pm = 1'b0;
      for (int k = 1; k <= 600; k++) begin
         if (mdc && !pm) begin cap = {cap[62:0], mdio_out}; ncap++; end
         pm = mdc;
         if (!mdio_oe) oe0++;
         if (!cmd_ready) rdy0++;
         if (!cmd_valid) scramble();
         if (rsp_valid) begin rv_k = k; rdat = rsp_rdata; er = rsp_err; break; end
         tick();
      end
   endtask

   initial begin
      logic [63:0] cap;
      int          ncap, rv, oe0, rdy0, w;
      logic [15:0] rdat;
      logic        er;

      tick();
      chk_en = 1'b1;
      repeat (2) tick();
      chk("reset_ready", cmd_ready, 1'b0);
      chk("reset_oe", mdio_oe, 1'b0);
      chk("reset_rdata", rsp_rdata, 16'h0);
      reset = 1'b0;
      tick();
      chk("ready_after_reset", cmd_ready, 1'b1);

      // Write phy=1 reg=0 data=1140
      slv_mode = 0;
      send(1'b0, 5'd1, 5'd0, 16'h1140, w);
      observe(cap, ncap, rv, oe0, rdy0, rdat, er);
      chk("t1_bits", cap, 64'hFFFF_FFFF_5082_1140);
      chk("t1_nbits", ncap, 64);
      chk("t1_latency", rv, 257);
      chk("t1_oe_low", oe0, 1);
      chk("t1_err", er, 1'b0);

      // Read phy=3 reg=2, PHY answers 796D
      slv_mode = 1; slv_data = 16'h796D;
      send(1'b1, 5'd3, 5'd2, 16'h0, w);
      observe(cap, ncap, rv, oe0, rdy0, rdat, er);
      chk("t2_rdata", rdat, 16'h796D);
      chk("t2_err", er, 1'b0);
      chk("t2_oe_low", oe0, 73);
      chk("t2_latency", rv, 257);

      // Read with no PHY
      slv_mode = 0;
      send(1'b1, 5'd31, 5'd31, 16'h0, w);
      observe(cap, ncap, rv, oe0, rdy0, rdat, er);
      chk("t3_rdata", rdat, 16'hFFFF);
      chk("t3_err", er, 1'b1);

      // Second command held during a frame
      send(1'b0, 5'd7, 5'd3, 16'h0F0F, w);
      cmd_read = 1'b0; cmd_phy_addr = 5'd5; cmd_reg_addr = 5'd9; cmd_wdata = 16'hA5C3;
      cmd_valid = 1'b1;
      observe(cap, ncap, rv, oe0, rdy0, rdat, er);
      chk("t4_ready_low", rdy0, 257);
      send(1'b0, 5'd5, 5'd9, 16'hA5C3, w);
      chk("t4_accept_wait", w, 2);
      observe(cap, ncap, rv, oe0, rdy0, rdat, er);
      chk("t4_bits", cap, 64'hFFFF_FFFF_52A6_A5C3);

      // Reset at bit 40 of a write
      send(1'b0, 5'd2, 5'd4, 16'hBEEF, w);
      repeat (160) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_mdc", mdc, 1'b0);
      chk("t5_oe", mdio_oe, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_rsp_valid", rsp_valid, 1'b0);
      repeat (120) tick();
      slv_mode = 1; slv_data = 16'($urandom);
      send(1'b1, 5'd6, 5'd17, 16'h0, w);
      observe(cap, ncap, rv, oe0, rdy0, rdat, er);
      chk("t5_rdata", rdat, slv_data);
      chk("t5_latency", rv, 257);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      cfg_no_pre = 1'b1;
      slv_mode = 1; slv_data = 16'($urandom);
      send(1'b1, 5'd1, 5'd1, 16'h0, w);
      observe(cap, ncap, rv, oe0, rdy0, rdat, er);
      chk("t6_first_bits", cap[31:28], 4'b0110);
      chk("t6_nbits", ncap, 32);
      chk("t6_latency", rv, 129);
      cfg_no_pre = 1'b0;
`endif

      for (int it = 0; it < 16; it++) begin
         bit          r;
         logic [4:0]  pa, ra;
         logic [15:0] wd;
         r = 1'($urandom); pa = 5'($urandom); ra = 5'($urandom); wd = 16'($urandom);
         slv_mode = int'($urandom_range(0, 2));
         slv_data = 16'($urandom);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
         cfg_no_pre = 1'($urandom);
`endif
         repeat ($urandom_range(0, 3)) tick();
         send(r, pa, ra, wd, w);
         observe(cap, ncap, rv, oe0, rdy0, rdat, er);
         chk("rand_latency", rv, m_last);
         chk("rand_err", er, m_exp_err);
         if (r) chk("rand_rdata", rdat, m_exp_rdata);
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
